uart_rx: RTL and testbench

UART receiver for the Tang Nano 9K board: 8N1 serial frames on the `uart_rx` pin become bytes with a one-cycle write strobe. It sits directly upstream of the program loader, which packs byte pairs into 16-bit words for BRAM. It rejects line glitches and reports framing errors.

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote at mid-bit,
// one-cycle strobes for good bytes and framing errors.
module uart_rx #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200,
    parameter int CPB      = (CLK_FREQ + BAUD / 2) / BAUD,
    parameter int HALF     = CPB / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_wr,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CPB + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          s_a, s_b;
    logic [7:0]    data_n;
    logic          wr_n, err_n;
    logic          vote, decide, bit_end;

    assign vote    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    assign decide  = (cnt == C_DEC);
    assign bit_end = (cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            rx_data    <= 8'h00;
            rx_data_wr <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            rx_data    <= data_n;
            rx_data_wr <= wr_n;
            frame_err  <= err_n;
            busy       <= (state_n != IDLE);
            // The first two votes are captured here; the third is rx_s live at the decision.
            if (cnt == C_S0) s_a <= rx_s;
            if (cnt == C_S1) s_b <= rx_s;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = rx_data;
        wr_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (decide && vote) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (decide) sh_n = {vote, sh[7:1]};
                if (bit_end) begin
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end
            end
            STOP: begin
                cnt_n = cnt + 1'b1;
                if (decide) begin
                    cnt_n = '0;
                    if (vote) begin
                        data_n  = sh;
                        wr_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=16, HALF=8; strobe timing is checked
// against the cycle in which the start bit was put on the pin.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 2 + 9 * CPB + HALF + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_wr;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         wr_cyc_q[$];
    logic [7:0] wr_dat_q[$];
    int         err_cyc_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_data_wr(rx_data_wr),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_wr) begin
                wr_cyc_q.push_back(cyc);
                wr_dat_q.push_back(rx_data);
            end
            if (frame_err) err_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_mon();
        wr_cyc_q.delete();
        wr_dat_q.delete();
        err_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge ending the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int p);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        p  = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            idle(CPB);
        end
    endtask

    task automatic check_one_frame(input string name, input int p, input logic [7:0] d);
        checks++;
        if (wr_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL %s strobe_count actual=%0d expected=1", name, wr_cyc_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[0] !== p + LAT) begin
                failures++;
                $display("FAIL %s strobe_cycle actual=%0d expected=%0d", name, wr_cyc_q[0], p + LAT);
            end
            checks++;
            if (wr_dat_q[0] !== d) begin
                failures++;
                $display("FAIL %s data actual=%h expected=%h", name, wr_dat_q[0], d);
            end
        end
        checks++;
        if (err_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL %s frame_err_count actual=%0d expected=0", name, err_cyc_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        checks++;
        if ({rx_data, rx_data_wr, frame_err, busy} !== 11'h0) begin
            failures++;
            $display("FAIL reset_hold outputs actual=%h expected=000", {rx_data, rx_data_wr, frame_err, busy});
        end
        rst = 1'b0;
        clear_mon();
        idle(100);
        checks++;
        if ({rx_data, rx_data_wr, frame_err, busy} !== 11'h0) begin
            failures++;
            $display("FAIL reset_idle outputs actual=%h expected=000", {rx_data, rx_data_wr, frame_err, busy});
        end
        checks++;
        if (wr_cyc_q.size() + err_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL reset_idle strobes actual=%0d expected=0", wr_cyc_q.size() + err_cyc_q.size());
        end
    endtask

    task automatic test_single_frame();
        int p;
        clear_mon();
        send_byte(8'h5A, 1'b1, p);
        idle(20);
        check_one_frame("frame_5a", p, 8'h5A);
        checks++;
        if (rx_data !== 8'h5A) begin
            failures++;
            $display("FAIL frame_5a rx_data_hold actual=%h expected=5a", rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int p1, p2;
        clear_mon();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1, p1);
        send_byte(8'hFF, 1'b1, p2);
        idle(20);
        checks++;
        if (wr_cyc_q.size() != 2) begin
            failures++;
            $display("FAIL b2b strobe_count actual=%0d expected=2", wr_cyc_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[0] !== p1 + LAT || wr_cyc_q[1] !== p1 + 160 + LAT) begin
                failures++;
                $display("FAIL b2b strobe_cycles actual=%0d,%0d expected=%0d,%0d",
                         wr_cyc_q[0], wr_cyc_q[1], p1 + LAT, p1 + 160 + LAT);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_dat_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b data%0d actual=%h expected=%h", i, wr_dat_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL b2b frame_err_count actual=%0d expected=0", err_cyc_q.size());
        end
    endtask

    task automatic test_glitch(input int width);
        int n;
        clear_mon();
        n  = cyc;
        rx = 1'b0;
        idle(width);
        rx = 1'b1;
        wait_to(n + 6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch%0d busy_mid actual=%b expected=1", width, busy);
        end
        wait_to(n + 2 + HALF + 3);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch%0d busy_after actual=%b expected=0", width, busy);
        end
        idle(200);
        checks++;
        if (wr_cyc_q.size() + err_cyc_q.size() != 0 || rx_data !== 8'hFF) begin
            failures++;
            $display("FAIL glitch%0d strobes=%0d rx_data=%h expected strobes=0 rx_data=ff",
                     width, wr_cyc_q.size() + err_cyc_q.size(), rx_data);
        end
    endtask

    task automatic test_frame_error();
        int p;
        clear_mon();
        send_byte(8'h3C, 1'b0, p);
        idle(200);
        checks++;
        if (err_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL ferr err_count actual=%0d expected=1", err_cyc_q.size());
        end else begin
            checks++;
            if (err_cyc_q[0] !== p + LAT) begin
                failures++;
                $display("FAIL ferr err_cycle actual=%0d expected=%0d", err_cyc_q[0], p + LAT);
            end
        end
        checks++;
        if (wr_cyc_q.size() != 0 || rx_data !== 8'hFF) begin
            failures++;
            $display("FAIL ferr data strobes=%0d rx_data=%h expected strobes=0 rx_data=ff",
                     wr_cyc_q.size(), rx_data);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr busy_low_line actual=%b expected=1", busy);
        end
        rx = 1'b1;
        idle(5);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr busy_recover actual=%b expected=0", busy);
        end
        idle(20);
        clear_mon();
        send_byte(8'h81, 1'b1, p);
        idle(20);
        check_one_frame("after_ferr_81", p, 8'h81);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int p;
        clear_mon();
        b  = 8'hA5;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = b[4];
        idle(HALF);
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        checks++;
        if ({rx_data, rx_data_wr, frame_err, busy} !== 11'h0) begin
            failures++;
            $display("FAIL rst_mid outputs actual=%h expected=000", {rx_data, rx_data_wr, frame_err, busy});
        end
        rst = 1'b0;
        idle(200);
        checks++;
        if (wr_cyc_q.size() + err_cyc_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid no_strobe strobes=%0d busy=%b expected 0,0",
                     wr_cyc_q.size() + err_cyc_q.size(), busy);
        end
        clear_mon();
        send_byte(8'h11, 1'b1, p);
        idle(20);
        check_one_frame("after_rst_11", p, 8'h11);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch(1);
        test_glitch(3);
        test_frame_error();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
